// File: rtl/sd_cmd_phy.sv
// SD card CMD-line PHY: serialises a 48-bit command frame, then captures and
// checks the card's 48-bit or 136-bit (R2) response.
module sd_cmd_phy #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         new_command,
  input  logic [15:0]  command,
  input  logic [31:0]  argument,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic         cmd_busy,
  output logic         command_complete,
  output logic [127:0] response_o,
  output logic [3:0]   error_o
);

  localparam int unsigned FRAME_W = 48;
  localparam int unsigned R2_W    = 136;
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > R2_W) ? TIMEOUT_CYCLES : R2_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [1:0]  RT_NONE = 2'b00;
  localparam logic [1:0]  RT_R2   = 2'b01;

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT_RESP, ST_RECV, ST_DONE} state_t;

  // Bit-serial CRC7 (x^7+x^3+1, zero seed); leading zeros leave the CRC untouched,
  // so shorter fields are passed zero-extended to 120 bits.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 119; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [46:0]        r_tx, w_tx_nxt;
  logic [134:0]       r_rx, w_rx_nxt;
  logic [5:0]         r_index, w_index_nxt;
  logic [1:0]         r_rtype, w_rtype_nxt;
  logic               r_cmd_out, w_cmd_out_nxt;
  logic               r_cmd_oe, w_cmd_oe_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_complete, w_complete_nxt;
  logic [127:0]       r_resp, w_resp_nxt;
  logic [3:0]         r_err, w_err_nxt;

  logic [39:0]        w_tx_hdr;
  logic [47:0]        w_tx_frame;
  logic [135:0]       w_rx_full;
  logic               w_rx_last;
  logic               w_crc48_bad;
  logic               w_crc136_bad;
  logic               w_unused;

  assign w_tx_hdr     = {2'b01, command[13:8], argument};
  assign w_tx_frame   = {w_tx_hdr, crc7({80'b0, w_tx_hdr}), 1'b1};
  assign w_rx_full    = {r_rx, cmd_in};
  assign w_rx_last    = (r_rtype == RT_R2) ? (r_cnt == CNT_W'(R2_W - 1))
                                           : (r_cnt == CNT_W'(FRAME_W - 1));
  assign w_crc48_bad  = crc7({80'b0, w_rx_full[47:8]}) != w_rx_full[7:1];
  assign w_crc136_bad = crc7(w_rx_full[127:8]) != w_rx_full[7:1];
  assign w_unused     = ^{command[15:14], command[7:2], w_rx_full[135]};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_index_nxt   = r_index;
    w_rtype_nxt   = r_rtype;
    w_cmd_out_nxt = 1'b1;
    w_cmd_oe_nxt  = 1'b0;
    w_resp_nxt    = r_resp;
    w_err_nxt     = r_err;
    case (r_state)
      ST_IDLE: begin
        if (new_command) begin
          w_index_nxt   = command[13:8];
          w_rtype_nxt   = command[1:0];
          w_tx_nxt      = w_tx_frame[46:0];
          w_cmd_out_nxt = w_tx_frame[47];
          w_cmd_oe_nxt  = 1'b1;
          w_rx_nxt      = '0;
          w_cnt_nxt     = '0;
          w_resp_nxt    = '0;
          w_err_nxt     = '0;
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_cnt == CNT_W'(FRAME_W - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_rtype == RT_NONE) ? ST_DONE : ST_WAIT_RESP;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
          w_tx_nxt      = {r_tx[45:0], 1'b1};
          w_cmd_out_nxt = r_tx[46];
          w_cmd_oe_nxt  = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        // The start bit itself is the first received bit.
        if (!cmd_in) begin
          w_rx_nxt    = w_rx_full[134:0];
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_RECV;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_err_nxt[0] = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RECV: begin
        w_rx_nxt = w_rx_full[134:0];
        if (w_rx_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DONE;
          if (r_rtype == RT_R2) begin
            w_resp_nxt = {8'b0, w_rx_full[127:8]};
            w_err_nxt  = {1'b0, ~w_rx_full[0], w_crc136_bad, 1'b0};
          end else begin
            w_resp_nxt = {96'b0, w_rx_full[39:8]};
            w_err_nxt  = {w_rx_full[45:40] != r_index, ~w_rx_full[0], w_crc48_bad, 1'b0};
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_complete_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_index    <= '0;
      r_rtype    <= '0;
      r_cmd_out  <= 1'b1;
      r_cmd_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_resp     <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_index    <= w_index_nxt;
      r_rtype    <= w_rtype_nxt;
      r_cmd_out  <= w_cmd_out_nxt;
      r_cmd_oe   <= w_cmd_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_complete <= w_complete_nxt;
      r_resp     <= w_resp_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign cmd_out          = r_cmd_out;
  assign cmd_oe           = r_cmd_oe;
  assign cmd_busy         = r_busy;
  assign command_complete = r_complete;
  assign response_o       = r_resp;
  assign error_o          = r_err;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: a cycle-timeline model of each transaction
// is compared against the DUT outputs every cycle.
module tb_sd_cmd_phy;

  localparam int TO = 64;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         new_command = 1'b0;
  logic [15:0]  command = '0;
  logic [31:0]  argument = '0;
  logic         cmd_in = 1'b1;
  logic         cmd_out, cmd_oe, cmd_busy, command_complete;
  logic [127:0] response_o;
  logic [3:0]   error_o;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [3:0]   e_ctrl;   // {busy, oe, out, complete}
  logic [127:0] e_resp;
  logic [3:0]   e_err;
  logic [127:0] h_resp = '0;
  logic [3:0]   h_err = '0;

  always #5 clock = ~clock;

  sd_cmd_phy #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .new_command(new_command), .command(command),
    .argument(argument), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
    .cmd_busy(cmd_busy), .command_complete(command_complete),
    .response_o(response_o), .error_o(error_o)
  );

  // CRC7 as the remainder of polynomial long division by 0x89.
  function automatic logic [6:0] crc7_div(input logic [119:0] d);
    logic [126:0] v;
    v = {d, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_div({80'b0, h}), 1'b1};
  endfunction

  function automatic logic [47:0] resp48(input logic [5:0] idx, input logic [31:0] pay);
    logic [39:0] h;
    h = {2'b00, idx, pay};
    return {h, crc7_div({80'b0, h}), 1'b1};
  endfunction

  function automatic logic [135:0] resp136(input logic [119:0] pay);
    return {8'h3F, pay, crc7_div(pay), 1'b1};
  endfunction

  // Expected {response_o, error_o} for a received frame.
  function automatic logic [131:0] model_resp(input logic [1:0] rt, input logic [5:0] idx,
                                              input logic [135:0] f);
    logic [127:0] r;
    logic [3:0]   e;
    if (rt == 2'b01) begin
      r = {8'b0, f[127:8]};
      e = {1'b0, ~f[0], crc7_div(f[127:8]) != f[7:1], 1'b0};
    end else begin
      r = {96'b0, f[39:8]};
      e = {f[45:40] != idx, ~f[0], crc7_div({80'b0, f[47:8]}) != f[7:1], 1'b0};
    end
    return {r, e};
  endfunction

  task automatic check_cycle();
    n_tests++;
    if ({cmd_busy, cmd_oe, cmd_out, command_complete} !== e_ctrl) begin
      n_fail++;
      $display("FAIL ctrl @%0t {busy,oe,out,complete} got %b want %b", $time,
               {cmd_busy, cmd_oe, cmd_out, command_complete}, e_ctrl);
    end
    n_tests++;
    if (response_o !== e_resp) begin
      n_fail++;
      $display("FAIL response_o @%0t got %h want %h", $time, response_o, e_resp);
    end
    n_tests++;
    if (error_o !== e_err) begin
      n_fail++;
      $display("FAIL error_o @%0t got %b want %b", $time, error_o, e_err);
    end
  endtask

  task automatic lit(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; new_command = 1'b0;
      command = 16'($urandom); argument = $urandom; cmd_in = 1'($urandom);
      e_ctrl = 4'b0010; e_resp = h_resp; e_err = h_err;
      tick();
    end
  endtask

  // One command; dly<0 or dly>=TO means the card never answers.
  task automatic run_cmd(input logic [1:0] rt, input logic [5:0] idx, input logic [31:0] arg,
                         input int dly, input logic [135:0] rf, input int pulse_at,
                         input int rst_at, output logic [47:0] tx_seen,
                         output logic [127:0] resp_seen, output logic [3:0] err_seen);
    logic [47:0]  fr;
    logic [131:0] m;
    int           nb, done, last;
    bit           answers;
    fr = cmd_frame(idx, arg);
    nb = (rt == 2'b01) ? 136 : 48;
    answers = (rt != 2'b00) && (dly >= 0) && (dly < TO);
    if (rt == 2'b00)  begin done = 49;            m = '0; end
    else if (!answers) begin done = 49 + TO;      m = {128'b0, 4'b0001}; end
    else begin done = 49 + dly + nb; m = model_resp(rt, idx, rf); end
    if (rst_at > done) rst_at = -1;
    if (rst_at >= 0 && pulse_at > rst_at) pulse_at = -1;
    last = (rst_at >= 0) ? rst_at + 3 : done + 1;
    tx_seen = '0; resp_seen = '0; err_seen = '0;
    for (int k = 0; k <= last; k++) begin
      new_command = (k == 0) || (k == pulse_at);
      command  = (k == 0) ? {2'($urandom), idx, 6'($urandom), rt} : 16'($urandom);
      argument = (k == 0) ? arg : $urandom;
      cmd_in   = 1'b1;
      if (answers && k >= 49 + dly && k < 49 + dly + nb) cmd_in = rf[nb - 1 - (k - 49 - dly)];
      reset = (rst_at >= 0) && (k >= rst_at) && (k < rst_at + 2);
      if (rst_at >= 0 && k > rst_at) begin e_ctrl = 4'b0010; e_resp = '0; e_err = '0; end
      else if (k == 0)    begin e_ctrl = 4'b0010; e_resp = h_resp; e_err = h_err; end
      else if (k <= 48)   begin e_ctrl = {2'b11, fr[48 - k], 1'b0}; e_resp = '0; e_err = '0; end
      else if (k < done)  begin e_ctrl = 4'b1010; e_resp = '0; e_err = '0; end
      else if (k == done) begin e_ctrl = 4'b1011; e_resp = m[131:4]; e_err = m[3:0]; end
      else                begin e_ctrl = 4'b0010; e_resp = m[131:4]; e_err = m[3:0]; end
      @(negedge clock);
      check_cycle();
      if (k >= 1 && k <= 48) tx_seen[48 - k] = cmd_out;
      if (k == done) begin resp_seen = response_o; err_seen = error_o; end
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    h_resp = (rst_at >= 0) ? '0 : m[131:4];
    h_err  = (rst_at >= 0) ? '0 : m[3:0];
  endtask

  initial begin
    logic [47:0]  tx;
    logic [127:0] rs;
    logic [3:0]   er;
    logic [135:0] r8;
    logic [135:0] rf;
    logic [119:0] pay;
    logic [1:0]   rt;
    logic [5:0]   idx;
    logic [31:0]  arg;
    int           pos, dly, pulse, rst;

    // Reset state
    @(posedge clock); @(posedge clock); #1;
    for (int i = 0; i < 2; i++) begin
      e_ctrl = 4'b0010; e_resp = '0; e_err = '0;
      tick();
    end
    reset = 1'b0;
    idle(3);

    // Pin the model to known SD frames
    lit("crc7_cmd0", 128'(crc7_div(120'h40_0000_0000)), 128'h4A);
    lit("crc7_cmd8", 128'(crc7_div(120'h48_0000_01AA)), 128'h43);
    lit("frame_cmd0", 128'(cmd_frame(6'd0, 32'h0)), 128'h400000000095);
    lit("frame_cmd8", 128'(cmd_frame(6'd8, 32'h1AA)), 128'h48000001AA87);
    lit("resp_r7", 128'(resp48(6'd8, 32'h1AA)), 128'h08000001AA13);

    // CMD0, no response
    run_cmd(2'b00, 6'd0, 32'h0, -1, '0, -1, -1, tx, rs, er);
    lit("cmd0_tx", 128'(tx), 128'h400000000095);
    lit("cmd0_err", 128'(er), 128'h0);
    idle(2);

    // CMD8 with good R7
    r8 = {88'b0, 48'h08000001AA13};
    run_cmd(2'b10, 6'd8, 32'h1AA, 5, r8, -1, -1, tx, rs, er);
    lit("cmd8_tx", 128'(tx), 128'h48000001AA87);
    lit("cmd8_resp", rs, 128'h1AA);
    lit("cmd8_err", 128'(er), 128'h0);
    idle(2);

    // Timeout
    run_cmd(2'b10, 6'd8, 32'h1AA, -1, r8, -1, -1, tx, rs, er);
    lit("timeout_err", 128'(er), 128'h1);
    idle(1);

    // CRC bit flipped
    run_cmd(2'b11, 6'd8, 32'h1AA, 5, r8 ^ 136'h2, -1, -1, tx, rs, er);
    lit("crc_err", 128'(er), 128'h2);
    lit("crc_resp", rs, 128'h1AA);

    // Index mismatch
    run_cmd(2'b10, 6'd8, 32'h1AA, 5, {88'b0, resp48(6'd9, 32'h1AA)}, -1, -1, tx, rs, er);
    lit("index_err", 128'(er), 128'h8);

    // Bad end bit, start bit on the last allowed wait cycle
    run_cmd(2'b10, 6'd8, 32'h1AA, TO - 1, r8 & ~136'h1, -1, -1, tx, rs, er);
    lit("end_err", 128'(er), 128'h4);

    // R2
    run_cmd(2'b01, 6'd2, 32'h0, 3, resp136(120'h0123456789ABCDEF_FEDCBA98765432), -1, -1,
            tx, rs, er);
    lit("r2_resp", rs, 128'h0123456789ABCDEF_FEDCBA98765432);
    lit("r2_err", 128'(er), 128'h0);
    idle(2);

    // Ignored pulse during SEND, then reset at SEND bit 20; reset mid-RECV
    run_cmd(2'b10, 6'd8, 32'h1AA, 5, r8, 10, 21, tx, rs, er);
    idle(2);
    run_cmd(2'b01, 6'd2, 32'h0, 5, resp136(120'h5A), -1, 49 + 5 + 20, tx, rs, er);
    idle(2);

    // Randomized transactions
    for (int t = 0; t < 36; t++) begin
      rt  = 2'($urandom);
      idx = 6'($urandom);
      arg = $urandom;
      pay = 120'({$urandom, $urandom, $urandom, $urandom});
      if (rt == 2'b01) begin
        rf = resp136(pay);
        pos = $urandom_range(0, 134);
      end else begin
        rf = {88'b0, resp48(($urandom_range(0, 3) == 0) ? 6'($urandom) : idx, $urandom)};
        pos = $urandom_range(0, 46);
      end
      if ($urandom_range(0, 2) == 0) rf[pos] = ~rf[pos];
      dly   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 3));
      pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 48)) : -1;
      rst   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 60)) : -1;
      run_cmd(rt, idx, arg, dly, rf, pulse, rst, tx, rs, er);
      idle(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_phy.md
SD_CMD_PHY -- requirements
Module: sd_cmd_phy

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum number of cycles to wait for a response start bit after the command end bit.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clock  in  1  system clock (wishbone/sd clock domain).
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 new_command  in  1  single-cycle request pulse from the wishbone slave.
REQ-006 command  in  16  command register; [13:8] index, [1:0] response type.
REQ-007 argument  in  32  argument register.
REQ-008 cmd_in  in  1  CMD line sampled from the card.
REQ-009 cmd_out  out  1  CMD line drive value.
REQ-010 cmd_oe  out  1  CMD line output enable.
REQ-011 cmd_busy  out  1  high while a command is in progress.
REQ-012 command_complete  out  1  single-cycle done pulse to the registers block.
REQ-013 response_o  out  128  captured response payload.
REQ-014 error_o  out  4  {index_err, end_bit_err, crc_err, timeout_err}.

Function
REQ-015 Response type encoding: 00 none; 01 136-bit (R2); 10 and 11 48-bit.
REQ-016 FSM states: IDLE, SEND, WAIT_RESP, RECV, DONE.
REQ-017 IDLE: new_command=1 latches command and argument, clears error_o and response_o, and enters SEND next cycle.
REQ-018 Transmit frame: 48 bits, MSB first, one bit per cycle = {0, 1, index[5:0], argument[31:0], CRC7, 1}.
REQ-019 CRC7: polynomial x^7+x^3+1, zero seed, computed over frame bits [47:8].
REQ-020 SEND: cmd_oe=1 for exactly 48 cycles; bit 47 is driven in the first SEND cycle.
REQ-021 After SEND: cmd_oe=0; type 00 goes to DONE, otherwise to WAIT_RESP.
REQ-022 WAIT_RESP: the counter increments each cycle; cmd_in=0 goes to RECV (that start bit is frame bit 0 of the count).
REQ-023 WAIT_RESP: if the counter reaches TIMEOUT_CYCLES without cmd_in=0, set timeout_err and go to DONE.
REQ-024 RECV: shift in the remaining 47 bits (48-bit type) or 135 bits (R2), then go to DONE.
REQ-025 48-bit checks: received index [45:40] != sent index sets index_err.
REQ-026 48-bit checks: CRC7 over [47:8] != [7:1] sets crc_err.
REQ-027 48-bit checks: bit [0] != 1 sets end_bit_err.
REQ-028 48-bit capture: response_o[31:0] = frame[39:8]; upper bits are 0.
REQ-029 R2 checks: CRC7 over frame[127:8] != frame[7:1] sets crc_err; index is not checked; end bit is checked as in REQ-027.
REQ-030 R2 capture: response_o[119:0] = frame[127:8]; upper bits are 0.
REQ-031 DONE: command_complete=1 for exactly one cycle, including on error, then return to IDLE.
REQ-032 cmd_busy=1 in every state except IDLE.
REQ-033 new_command while not IDLE SHALL be ignored with no effect on the transaction in progress.
REQ-034 error_o and response_o SHALL hold their values until the next accepted new_command.
REQ-035 cmd_out=1 whenever cmd_oe=0.

Reset
REQ-036 Reset SHALL force IDLE, cmd_out=1, cmd_oe=0, cmd_busy=0, command_complete=0, response_o=0, error_o=0, and counters=0.
REQ-037 Reset asserted mid-SEND or mid-RECV SHALL abort within one cycle with no command_complete pulse.

Verification
REQ-038 CMD0: index 0, arg 0, type 00 -> cmd_out serialises 0x400000000095 over 48 cycles; command_complete is asserted 1 cycle after the last bit; error_o=0.
REQ-039 CMD8: index 8, arg 0x000001AA, type 10, card returns 0x08000001AA13 after 5 idle cycles -> frame sent is 0x48000001AA87; response_o=0x000001AA; error_o=0.
REQ-040 Same stimulus as REQ-039 but cmd_in is held at 1 -> timeout_err=1 after TIMEOUT_CYCLES cycles; exactly one command_complete pulse.
REQ-041 Response as in REQ-039 with one CRC bit flipped -> crc_err=1; response_o is still captured.
REQ-042 Response as in REQ-039 with index 9 -> index_err=1.
REQ-043 new_command pulsed during SEND -> ignored; reset asserted at SEND bit 20 -> cmd_oe=0 the next cycle; no command_complete pulse.
